// File: rtl/ntsc_pack_pkg.sv
// rtl/ntsc_pack_pkg.sv - shared ntsc constants and pack state encodings
package ntsc_pack_pkg;

    localparam int PIX_W          = 18;
    localparam int WORD_W         = 36;
    localparam int CNT_W          = 10;
    localparam int H_PIXELS_DEF   = 640;
    localparam int V_LINES_DEF    = 480;
    localparam logic [PIX_W-1:0] PAD_DEF = 18'h0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVEN = 2'd1,
        ST_ODD  = 2'd2
    } pack_state_t;

endpackage

// File: rtl/ntsc_pack.sv
// rtl/ntsc_pack.sv - pairs 18-bit YCrCb pixels into 36-bit words with line/word coordinates
module ntsc_pack
    import ntsc_pack_pkg::*;
#(
    parameter int                H_PIXELS = H_PIXELS_DEF,
    parameter int                V_LINES  = V_LINES_DEF,
    parameter logic [PIX_W-1:0]  PAD      = PAD_DEF
) (
    input  logic                 clock_65mhz,
    input  logic                 reset,
    input  logic                 pixel_valid,
    input  logic [PIX_W-1:0]     pixel_data,
    input  logic                 sof,
    input  logic                 sol,
    output logic                 ntsc_flag,
    output logic [WORD_W-1:0]    ntsc_pixels,
    output logic [CNT_W-1:0]     ntsc_x,
    output logic [CNT_W-1:0]     ntsc_y,
    output logic                 line_overrun
);

    localparam logic [CNT_W-1:0] W_HALF = CNT_W'(H_PIXELS / 2);
    localparam logic [CNT_W-1:0] V_MAX  = CNT_W'(V_LINES);

    pack_state_t          r_state;
    logic [CNT_W-1:0]     r_line;
    logic [CNT_W-1:0]     r_word;
    logic [PIX_W-1:0]     r_held;

    pack_state_t          w_state_nx;
    logic [CNT_W-1:0]     w_line_nx;
    logic [CNT_W-1:0]     w_word_nx;
    logic [PIX_W-1:0]     w_held_nx;
    logic                 w_overrun_nx;
    logic                 w_emit;
    logic [WORD_W-1:0]    w_emit_word;

    always_comb begin
        w_state_nx   = r_state;
        w_line_nx    = r_line;
        w_word_nx    = r_word;
        w_held_nx    = r_held;
        w_overrun_nx = line_overrun;
        w_emit       = 1'b0;
        w_emit_word  = '0;

        case (r_state)
            ST_IDLE: begin
                if (sof) begin
                    w_line_nx = '0;
                    w_word_nx = '0;
                    if (pixel_valid) begin
                        w_held_nx  = pixel_data;
                        w_state_nx = ST_ODD;
                    end else begin
                        w_state_nx = ST_EVEN;
                    end
                end
            end
            default: begin
                if (sof || sol) begin
                    // Boundary: flush a lone held pixel with the pre-boundary coordinates.
                    if (r_state == ST_ODD) begin
                        w_emit      = 1'b1;
                        w_emit_word = {r_held, PAD};
                    end
                    if (sof)
                        w_line_nx = '0;
                    else if (r_line < V_MAX)
                        w_line_nx = r_line + CNT_W'(1);
                    w_word_nx  = '0;
                    w_state_nx = ST_EVEN;
                    if (pixel_valid) begin
                        if (w_line_nx >= V_MAX) begin
                            w_overrun_nx = 1'b1;
                        end else begin
                            w_held_nx  = pixel_data;
                            w_state_nx = ST_ODD;
                        end
                    end
                end else if (pixel_valid) begin
                    if (r_word >= W_HALF || r_line >= V_MAX) begin
                        w_overrun_nx = 1'b1;
                    end else if (r_state == ST_EVEN) begin
                        w_held_nx  = pixel_data;
                        w_state_nx = ST_ODD;
                    end else begin
                        w_emit      = 1'b1;
                        w_emit_word = {r_held, pixel_data};
                        w_word_nx   = r_word + CNT_W'(1);
                        w_state_nx  = ST_EVEN;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock_65mhz) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_line       <= '0;
            r_word       <= '0;
            r_held       <= '0;
            ntsc_flag    <= 1'b0;
            ntsc_pixels  <= '0;
            ntsc_x       <= '0;
            ntsc_y       <= '0;
            line_overrun <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_line       <= w_line_nx;
            r_word       <= w_word_nx;
            r_held       <= w_held_nx;
            line_overrun <= w_overrun_nx;
            ntsc_flag    <= w_emit;
            if (w_emit) begin
                ntsc_pixels <= w_emit_word;
                ntsc_x      <= r_word;
                ntsc_y      <= r_line;
            end
        end
    end

endmodule

// File: tb/tb_ntsc_pack.sv
// tb/tb_ntsc_pack.sv - directed scoreboard bench for ntsc_pack
module tb_ntsc_pack;

    localparam logic [17:0] PAD_V = 18'h2AAAA;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pixel_valid = 1'b0;
    logic [17:0] pixel_data = '0;
    logic        sof = 1'b0;
    logic        sol = 1'b0;
    logic        ntsc_flag;
    logic [35:0] ntsc_pixels;
    logic [9:0]  ntsc_x;
    logic [9:0]  ntsc_y;
    logic        line_overrun;

    int n_asserts = 0;
    int n_fail    = 0;
    int n_flags   = 0;
    int base;
    logic [55:0] sb[$];
    logic [55:0] exp_w;

    ntsc_pack #(.H_PIXELS(640), .V_LINES(480), .PAD(PAD_V)) dut (
        .clock_65mhz (clk),
        .reset       (reset),
        .pixel_valid (pixel_valid),
        .pixel_data  (pixel_data),
        .sof         (sof),
        .sol         (sol),
        .ntsc_flag   (ntsc_flag),
        .ntsc_pixels (ntsc_pixels),
        .ntsc_x      (ntsc_x),
        .ntsc_y      (ntsc_y),
        .line_overrun(line_overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ntsc_flag === 1'b1) begin
            n_flags++;
            n_asserts++;
            assert (sb.size() > 0) else begin
                n_fail++;
                $error("FAIL unexpected_flag observed pixels=%h x=%0d y=%0d required no flag",
                       ntsc_pixels, ntsc_x, ntsc_y);
            end
            if (sb.size() > 0) begin
                exp_w = sb.pop_front();
                n_asserts++;
                assert ({ntsc_pixels, ntsc_x, ntsc_y} === exp_w) else begin
                    n_fail++;
                    $error("FAIL word observed pixels=%h x=%0d y=%0d required pixels=%h x=%0d y=%0d",
                           ntsc_pixels, ntsc_x, ntsc_y, exp_w[55:20], exp_w[19:10], exp_w[9:0]);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h required=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [17:0] d, input logic f, input logic l);
        pixel_valid = v;
        pixel_data  = d;
        sof         = f;
        sol         = l;
        @(posedge clk);
        #1;
        pixel_valid = 1'b0;
        pixel_data  = '0;
        sof         = 1'b0;
        sol         = 1'b0;
    endtask

    task automatic push(input logic [35:0] w, input int x, input int y);
        sb.push_back({w, 10'(x), 10'(y)});
    endtask

    task automatic drain(input string tag);
        repeat (4) @(posedge clk);
        #1;
        chk(tag, 64'(sb.size()), 64'd0);
    endtask

    function automatic logic [17:0] pix(input int line_id, input int i);
        return 18'((line_id * 4099) ^ (i * 37 + 5));
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_flag", 64'(ntsc_flag), 64'd0);
        chk("rst_pixels", 64'(ntsc_pixels), 64'd0);
        chk("rst_x", 64'(ntsc_x), 64'd0);
        chk("rst_y", 64'(ntsc_y), 64'd0);
        chk("rst_overrun", 64'(line_overrun), 64'd0);
        @(posedge clk);
        #1;

        // idle ignores pixels and sol until sof
        cyc(1, 18'h11111, 0, 0);
        cyc(1, 18'h22222, 0, 1);
        cyc(1, 18'h33333, 0, 0);
        drain("idle_ignore");

        // first pair, coordinates 0/0
        push(36'h000040002, 0, 0);
        cyc(1, 18'h00001, 1, 0);
        cyc(1, 18'h00002, 0, 0);
        drain("first_pair");
        chk("hold_pixels", 64'(ntsc_pixels), 64'h000040002);

        // full line of 640 pixels then sol without flush
        cyc(0, 0, 1, 0);
        base = n_flags;
        for (int k = 0; k < 320; k++)
            push({pix(0, 2*k), pix(0, 2*k+1)}, k, 0);
        for (int i = 0; i < 640; i++)
            cyc(1, pix(0, i), 0, 0);
        cyc(0, 0, 0, 1);
        drain("full_line");
        chk("full_line_flags", 64'(n_flags - base), 64'd320);
        chk("full_line_last_x", 64'(ntsc_x), 64'd319);
        push({pix(1, 0), pix(1, 1)}, 0, 1);
        cyc(1, pix(1, 0), 0, 0);
        cyc(1, pix(1, 1), 0, 0);
        drain("line1_pair");

        // odd pixel count flushed by sol carrying next line's first pixel
        cyc(0, 0, 1, 0);
        push({18'h0000A, 18'h0000B}, 0, 0);
        push({18'h0000C, PAD_V}, 1, 0);
        push({18'h0000D, 18'h0000E}, 0, 1);
        cyc(1, 18'h0000A, 0, 0);
        cyc(1, 18'h0000B, 0, 0);
        cyc(1, 18'h0000C, 0, 0);
        cyc(1, 18'h0000D, 0, 1);
        cyc(1, 18'h0000E, 0, 0);
        drain("flush_sol");

        // 642 pixels: two dropped, overrun sticky through sof
        cyc(0, 0, 1, 0);
        base = n_flags;
        for (int k = 0; k < 320; k++)
            push({pix(2, 2*k), pix(2, 2*k+1)}, k, 0);
        for (int i = 0; i < 642; i++)
            cyc(1, pix(2, i), 0, 0);
        drain("overrun_line");
        chk("overrun_flags", 64'(n_flags - base), 64'd320);
        chk("overrun_set", 64'(line_overrun), 64'd1);
        cyc(0, 0, 1, 0);
        chk("overrun_sticky", 64'(line_overrun), 64'd1);
        push({18'h12345, 18'h23456}, 0, 0);
        cyc(1, 18'h12345, 0, 0);
        cyc(1, 18'h23456, 0, 0);
        drain("after_overrun");

        // sof mid-line in ODD on line 5
        cyc(0, 0, 1, 0);
        repeat (5) cyc(0, 0, 0, 1);
        push({18'h00101, 18'h00102}, 0, 5);
        push({18'h00103, PAD_V}, 1, 5);
        push({18'h00104, 18'h00105}, 0, 0);
        cyc(1, 18'h00101, 0, 0);
        cyc(1, 18'h00102, 0, 0);
        cyc(1, 18'h00103, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(1, 18'h00104, 0, 0);
        cyc(1, 18'h00105, 0, 0);
        drain("sof_flush");
        chk("sof_flush_y", 64'(ntsc_y), 64'd0);

        // reset one cycle after a held pixel, with a pixel in the reset cycle
        cyc(1, 18'h3FFFF, 1, 0);
        reset = 1'b1;
        cyc(1, 18'h3F0F0, 0, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_flag", 64'(ntsc_flag), 64'd0);
        chk("mid_rst_pixels", 64'(ntsc_pixels), 64'd0);
        chk("mid_rst_xy", 64'({ntsc_x, ntsc_y}), 64'd0);
        chk("mid_rst_overrun", 64'(line_overrun), 64'd0);
        @(posedge clk);
        #1;
        cyc(1, 18'h01111, 0, 0);
        cyc(1, 18'h02222, 0, 0);
        drain("post_rst_ignore");
        cyc(0, 0, 1, 0);
        push({18'h05555, 18'h06666}, 0, 0);
        cyc(1, 18'h05555, 0, 0);
        cyc(1, 18'h06666, 0, 0);
        drain("post_rst_pair");

        // line counter saturates past V_LINES, pixels there are dropped
        cyc(0, 0, 1, 0);
        repeat (520) cyc(0, 0, 0, 1);
        cyc(1, 18'h07777, 0, 0);
        cyc(1, 18'h08888, 0, 0);
        cyc(1, 18'h09999, 0, 1);
        drain("line_sat_drop");
        chk("line_sat_overrun", 64'(line_overrun), 64'd1);
        push({18'h0AAAA, 18'h0BBBB}, 0, 0);
        cyc(1, 18'h0AAAA, 1, 0);
        cyc(1, 18'h0BBBB, 0, 0);
        drain("recover_pair");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
